// File: rtl/clken_gen.sv
// Multi-channel clock-enable generator with glitch-free divisor updates and
// a stretched downstream reset.
module clken_gen #(
    parameter int unsigned NCH      = 3,
    parameter int unsigned CW       = 8,
    parameter int unsigned DIV_RST  = 2,
    parameter int unsigned RST_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   div_wr,
    input  logic [CW-1:0]    div_wdata,
    input  logic             resync,
    output logic [NCH-1:0]   ce,
    output logic [NCH-1:0]   phase,
    output logic             rst_out
);

    localparam int unsigned HW = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

    logic [HW-1:0] hold_q;
    logic          rst_out_q;

    // rst_out falls on the edge after the hold counter reaches RST_HOLD
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q    <= '0;
            rst_out_q <= 1'b1;
        end else if (rst_out_q) begin
            if (hold_q == HW'(RST_HOLD)) begin
                rst_out_q <= 1'b0;
            end else begin
                hold_q <= hold_q + HW'(1);
            end
        end
    end

    assign rst_out = rst_out_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] div_act_q;
        logic [CW-1:0] div_pend_q;
        logic          wrap;
        logic [CW-1:0] div_nxt;

        assign wrap    = (cnt_q == div_act_q);
        // A write coinciding with a wrap or resync takes effect immediately
        assign div_nxt = div_wr[i] ? div_wdata : div_pend_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q      <= '0;
                div_act_q  <= CW'(DIV_RST);
                div_pend_q <= CW'(DIV_RST);
            end else begin
                if (div_wr[i]) begin
                    div_pend_q <= div_wdata;
                end
                if (!rst_out_q) begin
                    if (resync || wrap) begin
                        cnt_q     <= '0;
                        div_act_q <= div_nxt;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            end
        end

        assign ce[i]    = wrap & ~rst_out_q;
        assign phase[i] = (cnt_q <= (div_act_q >> 1)) & ~rst_out_q;
    end

endmodule

// File: tb/tb_clken_gen.sv
// Directed bench for clken_gen: a time-based period model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_clken_gen;

    localparam int NCH      = 3;
    localparam int CW       = 8;
    localparam int DIV_RST  = 2;
    localparam int RST_HOLD = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] div_wr;
    logic [CW-1:0]  div_wdata;
    logic           resync;
    logic [NCH-1:0] ce;
    logic [NCH-1:0] phase;
    logic           rst_out;

    int n_cmp = 0;
    int n_bad = 0;

    clken_gen #(
        .NCH      (NCH),
        .CW       (CW),
        .DIV_RST  (DIV_RST),
        .RST_HOLD (RST_HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .div_wr    (div_wr),
        .div_wdata (div_wdata),
        .resync    (resync),
        .ce        (ce),
        .phase     (phase),
        .rst_out   (rst_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: each channel is described by the cycle its current period began
    // and that period's length; outputs follow from the age within the period.
    int m_cyc   = 0;
    int m_since = 0;
    bit m_valid = 0;
    int m_start [NCH];
    int m_len   [NCH];
    int m_pend  [NCH];

    function automatic bit exp_rst();
        return m_since <= RST_HOLD;
    endfunction

    always @(posedge clk) begin
        bit old_rst;
        int nxt;
        old_rst = exp_rst();
        m_cyc++;
        if (reset) begin
            m_valid = 1;
            m_since = 0;
            for (int i = 0; i < NCH; i++) begin
                m_pend[i]  = DIV_RST;
                m_len[i]   = DIV_RST + 1;
                m_start[i] = m_cyc;
            end
        end else if (m_valid) begin
            m_since++;
            for (int i = 0; i < NCH; i++) begin
                nxt = div_wr[i] ? int'(div_wdata) : m_pend[i];
                if (old_rst) begin
                    m_start[i] = m_cyc;
                end else if (resync || (m_cyc - 1 - m_start[i] == m_len[i] - 1)) begin
                    m_start[i] = m_cyc;
                    m_len[i]   = nxt + 1;
                end
                if (div_wr[i]) m_pend[i] = int'(div_wdata);
            end
        end
    end

    always @(negedge clk) begin
        logic [NCH-1:0] e_ce;
        logic [NCH-1:0] e_ph;
        int age;
        if (m_valid) begin
            for (int i = 0; i < NCH; i++) begin
                age     = m_cyc - m_start[i];
                e_ce[i] = !exp_rst() && (age == m_len[i] - 1);
                e_ph[i] = !exp_rst() && (age <= (m_len[i] - 1) / 2);
            end
            check("model_rst_out", int'(rst_out), int'(exp_rst()));
            check("model_ce", int'(ce), int'(e_ce));
            check("model_phase", int'(phase), int'(e_ph));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int hold_seen;
        logic [5:0] ph6;
        logic [5:0] ce6;
        logic [7:0] ph8;
        logic [7:0] ce8;
        reset     = 1'b1;
        div_wr    = '0;
        div_wdata = '0;
        resync    = 1'b0;

        // Reset release and hold (k = cycles after the reset edge)
        tick();                                 // k0
        check("rst_k0", int'(rst_out), 1);
        check("ce_k0", int'(ce), 0);
        check("phase_k0", int'(phase), 0);
        reset = 1'b0;
        hold_seen = 0;
        repeat (4) begin
            tick();                             // k1..k4
            if (rst_out) hold_seen++;
        end
        tick();                                 // k5
        check("hold_len", hold_seen, 4);
        check("rst_k5", int'(rst_out), 0);
        check("phase_k5", int'(phase), 3'b111);
        tick();                                 // k6
        check("ce_k6", int'(ce), 0);
        tick();                                 // k7
        check("ce_first", int'(ce), 3'b111);
        check("phase_k7", int'(phase), 0);
        repeat (3) tick();                      // k10
        check("ce_k10", int'(ce), 3'b111);

        // ch1 to divisor 0 while its counter is 0
        tick();                                 // k11
        div_wr = 3'b010; div_wdata = 8'd0;
        tick();                                 // k12
        div_wr = '0;
        check("div0_k12", int'(ce), 0);
        tick();                                 // k13
        check("div0_k13", int'(ce), 3'b111);
        tick();                                 // k14
        check("div0_k14", int'(ce), 3'b010);
        tick();                                 // k15
        check("div0_k15", int'(ce), 3'b010);
        tick();                                 // k16

        // ch0 to divisor 5 in its ce cycle: bypass
        check("bypass_pre", int'(ce), 3'b111);
        div_wr = 3'b001; div_wdata = 8'd5;
        for (int j = 0; j < 6; j++) begin
            tick();                             // k17..k22
            div_wr = '0;
            ph6[j] = phase[0];
            ce6[j] = ce[0];
        end
        check("bypass_phase", int'(ph6), 6'b000111);
        check("bypass_ce", int'(ce6), 6'b100000);

        // Divisors 1, 2, 4 then resync at counts 1, 0, 3
        div_wr = 3'b001; div_wdata = 8'd1;
        tick();
        div_wr = 3'b010; div_wdata = 8'd2;
        tick();
        div_wr = 3'b100; div_wdata = 8'd4;
        tick();
        div_wr = '0; resync = 1'b1;
        tick();                                 // t0: all counters 0
        resync = 1'b0;
        repeat (3) tick();                      // counts 1, 0, 3
        check("pre_resync_ce", int'(ce), 3'b001);
        resync = 1'b1;
        tick();                                 // +1
        resync = 1'b0;
        check("resync_p1_ce", int'(ce), 0);
        check("resync_p1_phase", int'(phase), 3'b111);
        tick();
        check("resync_p2", int'(ce), 3'b001);
        tick();
        check("resync_p3", int'(ce), 3'b010);
        tick();
        check("resync_p4", int'(ce), 3'b001);
        tick();                                 // +5, ch2 counter 4
        check("resync_p5", int'(ce), 3'b100);

        // Reset mid-period with ch2 at count 2
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("midrst_ce", int'(ce), 0);
        check("midrst_rst", int'(rst_out), 1);
        tick();
        reset = 1'b0;
        repeat (4) tick();
        check("midrst_hold_end", int'(rst_out), 1);
        tick();
        check("midrst_released", int'(rst_out), 0);
        tick();
        check("midrst_ce_wait", int'(ce), 0);
        tick();
        check("midrst_ce_first", int'(ce), 3'b111);
        repeat (3) tick();
        check("midrst_ce_next", int'(ce), 3'b111);

        // Write and resync together: 8-cycle periods, in phase
        tick();
        div_wr = 3'b111; div_wdata = 8'd7; resync = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            div_wr = '0; resync = 1'b0;
            ph8[j] = &phase;
            ce8[j] = |ce;
        end
        check("sync8_phase", int'(ph8), 8'b00001111);
        check("sync8_ce", int'(ce8), 8'b10000000);
        check("sync8_all_ce", int'(ce), 3'b111);

        // resync and writes during the hold window
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        resync = 1'b1; div_wr = 3'b100; div_wdata = 8'd3;
        tick();
        resync = 1'b0; div_wr = '0;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clken_gen.md
CLKEN_GEN -- requirements
Module: clken_gen

Interface
REQ-001 The block SHALL have parameter NCH, default 3: number of clock-enable channels.
REQ-002 The block SHALL have parameter CW, default 8: divisor and counter width in bits.
REQ-003 The block SHALL have parameter DIV_RST, default 2: divisor loaded into every channel at reset.
REQ-004 The block SHALL have parameter RST_HOLD, default 16: number of cycles rst_out is held after reset deasserts.
REQ-005 Port clk  input  1: the block's one clock; all state changes on its rising edge.
REQ-006 Port reset  input  1: reset, synchronous and active-high.
REQ-007 Port div_wr  input  NCH: per-channel divisor write strobe.
REQ-008 Port div_wdata  input  CW: divisor value, shared by all channels.
REQ-009 Port resync  input  1: realigns all channel counters.
REQ-010 Port ce  output  NCH: per-channel one-cycle enable pulse.
REQ-011 Port phase  output  NCH: per-channel half-period phase level.
REQ-012 Port rst_out  output  1: stretched, active-high reset for downstream logic.

Function
REQ-013 Each channel SHALL hold a counter cnt[i] (CW bits), an active divisor div_act[i] and a pending divisor div_pend[i]; channel period SHALL be div_act[i]+1 cycles.
REQ-014 A hold counter SHALL keep rst_out=1 for exactly RST_HOLD cycles after the first clk edge with reset=0; rst_out SHALL then stay 0 until the next reset.
REQ-015 While rst_out=1: all cnt SHALL be held at 0, ce=0, phase=0.
REQ-016 While rst_out=0: cnt[i] SHALL increment by 1 per cycle and wrap to 0 on the cycle after cnt[i]==div_act[i]; no arithmetic overflow beyond the wrap is possible.
REQ-017 ce[i] SHALL equal (cnt[i]==div_act[i]) AND NOT rst_out, decoded from registered state only.
REQ-018 phase[i] SHALL equal (cnt[i] <= div_act[i]>>1) AND NOT rst_out.
REQ-019 div_act[i]=0 SHALL give ce[i]=1 and phase[i]=1 on every cycle with rst_out=0.
REQ-020 div_wr[i]=1 SHALL load div_wdata into div_pend[i] at the clock edge; several strobes in one cycle SHALL load the same value into each selected channel.
REQ-021 div_act[i] SHALL update from div_pend[i] only at a wrap (a cycle with ce[i]=1) or on resync; the running period SHALL never be shortened or stretched mid-period.
REQ-022 If div_wr[i] and the channel i wrap (or resync) occur in the same cycle, div_wdata SHALL bypass into div_act[i] for the next period.
REQ-023 resync=1 (with rst_out=0) SHALL set every cnt to 0 and every div_act to its pending value (bypass per REQ-022) at the next edge; resync SHALL take priority over a normal increment or wrap.
REQ-024 resync while rst_out=1 SHALL have no effect.

Reset
REQ-025 reset=1 at an edge SHALL force: cnt=0, div_act=div_pend=DIV_RST for all channels, hold counter=0, rst_out=1; hence ce=0 and phase=0 from the following cycle.
REQ-026 reset SHALL take priority over div_wr and resync in the same cycle.
REQ-027 Assertion of reset mid-period SHALL abort all periods with no further ce pulse; the hold sequence of REQ-014 SHALL restart when reset deasserts.

Verification (NCH=3, CW=8, DIV_RST=2, RST_HOLD=4)
REQ-028 Reset for 1 cycle, then release -> rst_out=1 for 4 cycles, then 0; every ce first pulses in the 3rd cycle with rst_out=0 and then every 3 cycles, all channels aligned.
REQ-029 div_wr=3'b010, div_wdata=0 at cnt[1]=0 -> ch1 completes its current 3-cycle period; ce[1]=1 on every cycle after that; ch0 and ch2 unchanged.
REQ-030 div_wr=3'b001, div_wdata=5 in a cycle where ce[0]=1 -> the next ch0 period is 6 cycles (bypass), with phase[0] high 3 cycles and low 3 cycles.
REQ-031 Channels set to divisors 1, 2 and 4; resync pulsed with cnt values 1, 0 and 3 -> all cnt=0 on the next cycle; ce pulses at cycles +2, +3 and +5 after resync.
REQ-032 reset asserted for 2 cycles while ch2 runs div=4 at cnt=2 -> ce=0 and rst_out=1 from the next cycle; after release, period 3 (DIV_RST) resumes after the 4-cycle hold.
REQ-033 div_wr and resync asserted together with div_wdata=7 on all channels -> the next period on all channels is 8 cycles, starting in phase.
